// File: rtl/qc_shift_table.sv
// qc_shift_table: loadable multi-bank table of QC-LDPC circulant shift values.
// Firmware writes individual entries; a start request streams one fully loaded
// bank to the encoder, one row per valid/ready handshake.
module qc_shift_table #(
  parameter int ROWS    = 16,
  parameter int COLS    = 3,
  parameter int SHIFT_W = 9,
  parameter int Z       = 512,
  parameter int BANKS   = 2,
  localparam int BW     = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [BW-1:0]             wr_bank,
  input  logic [RW-1:0]             wr_row,
  input  logic [CW-1:0]             wr_col,
  input  logic [SHIFT_W-1:0]        wr_shift,
  output logic                      wr_err,
  input  logic [BANKS-1:0]          bank_clr,
  output logic [BANKS-1:0]          bank_ready,
  input  logic                      start,
  input  logic [BW-1:0]             start_bank,
  output logic                      start_err,
  input  logic                      abort,
  output logic                      busy,
  output logic                      row_vld,
  input  logic                      row_rdy,
  output logic [RW-1:0]             row_idx,
  output logic [COLS*SHIFT_W-1:0]   row_shifts,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  // Table storage: one packed row word per (bank,row); col0 occupies the MSBs.
  logic [COLS*SHIFT_W-1:0] mem_q [BANKS][ROWS];
  // Per-bank map of entries written since reset or the last clear.
  logic [ROWS*COLS-1:0]    loaded_q [BANKS];

  state_t                  state_q, state_d;
  logic [BW-1:0]           bank_q, bank_d;
  logic                    row_vld_q, row_vld_d;
  logic [RW-1:0]           row_idx_q, row_idx_d;
  logic [COLS*SHIFT_W-1:0] row_shifts_q, row_shifts_d;
  logic                    done_q, done_d;
  logic                    start_err_q, start_err_d;
  logic                    wr_err_q;

  logic                    wr_in_range;
  logic                    wr_shift_ok;
  logic                    wr_locked;
  logic                    wr_ok;
  int                      wr_lsb;
  int                      wr_bit;
  logic                    start_ok;
  logic [RW-1:0]           next_idx;
  logic                    last_row;

  // A write is legal when every index is in range, the shift is a legal
  // circulant offset and the target bank is not the one being streamed.
  assign wr_in_range = (int'(wr_bank) < BANKS) && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign wr_shift_ok = int'(wr_shift) < Z;
  assign wr_locked   = busy && (wr_bank == bank_q);
  assign wr_ok       = wr_en && wr_in_range && wr_shift_ok && !wr_locked;
  assign wr_lsb      = (COLS - 1 - int'(wr_col)) * SHIFT_W;
  assign wr_bit      = int'(wr_row) * COLS + int'(wr_col);

  assign start_ok    = (int'(start_bank) < BANKS) && bank_ready[start_bank];
  assign next_idx    = row_idx_q + RW'(1);
  assign last_row    = (int'(row_idx_q) == ROWS - 1);

  // A bank is ready once every one of its entries has been loaded.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_ready
    assign bank_ready[gi] = &loaded_q[gi];
  end

  // Entry storage; data survives a bank clear, only the loaded map is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        for (int r = 0; r < ROWS; r++)
          mem_q[b][r] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_bank][wr_row][wr_lsb +: SHIFT_W] <= wr_shift;
    end
  end

  // Loaded map update; a clear beats a same-cycle write to the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        loaded_q[b] <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (bank_clr[b])
          loaded_q[b] <= '0;
        else if (wr_ok && (int'(wr_bank) == b))
          loaded_q[b][wr_bit] <= 1'b1;
      end
    end
  end

  // Write rejection flag, raised for exactly the cycle after a refused write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_en && !wr_ok;
  end

  // Stream FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bank_q       <= '0;
      row_vld_q    <= 1'b0;
      row_idx_q    <= '0;
      row_shifts_q <= '0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      row_vld_q    <= row_vld_d;
      row_idx_q    <= row_idx_d;
      row_shifts_q <= row_shifts_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
    end
  end

  // Stream FSM next state: rows are held until accepted, abort wins over a handshake.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    row_vld_d    = row_vld_q;
    row_idx_d    = row_idx_q;
    row_shifts_d = row_shifts_q;
    done_d       = 1'b0;
    start_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d      = S_STREAM;
            bank_d       = start_bank;
            row_vld_d    = 1'b1;
            row_idx_d    = '0;
            row_shifts_d = mem_q[start_bank][0];
          end else begin
            start_err_d  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        start_err_d = start;
        if (abort) begin
          state_d      = S_IDLE;
          row_vld_d    = 1'b0;
          row_idx_d    = '0;
          row_shifts_d = '0;
        end else if (row_vld_q && row_rdy) begin
          if (last_row) begin
            state_d      = S_DONE;
            row_vld_d    = 1'b0;
            row_idx_d    = '0;
            row_shifts_d = '0;
            done_d       = 1'b1;
          end else begin
            row_idx_d    = next_idx;
            row_shifts_d = mem_q[bank_q][next_idx];
          end
        end
      end
      S_DONE: begin
        start_err_d = start;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign wr_err     = wr_err_q;
  assign start_err  = start_err_q;
  assign row_vld    = row_vld_q;
  assign row_idx    = row_idx_q;
  assign row_shifts = row_shifts_q;
  assign done       = done_q;

endmodule

// File: tb/tb_qc_shift_table.sv
// Self-checking bench for qc_shift_table: table-driven writes, scoreboarded streams,
// and hand-written sequences for stall, lock, abort, clear and mid-stream reset.
module tb_qc_shift_table;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_row;
  logic [1:0]  wr_col;
  logic [8:0]  wr_shift;
  logic        wr_err;
  logic [1:0]  bank_clr;
  logic [1:0]  bank_ready;
  logic        start;
  logic [0:0]  start_bank;
  logic        start_err;
  logic        abort;
  logic        busy;
  logic        row_vld;
  logic        row_rdy;
  logic [3:0]  row_idx;
  logic [26:0] row_shifts;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [8:0] mdl [2][16][3];

  typedef struct {
    int   bank;
    int   row;
    int   col;
    int   shift;
    logic exp_err;
  } wvec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [26:0] shifts;
  } row_t;

  row_t sb[$];

  qc_shift_table dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
    .wr_shift(wr_shift), .wr_err(wr_err),
    .bank_clr(bank_clr), .bank_ready(bank_ready),
    .start(start), .start_bank(start_bank), .start_err(start_err),
    .abort(abort), .busy(busy),
    .row_vld(row_vld), .row_rdy(row_rdy), .row_idx(row_idx),
    .row_shifts(row_shifts), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [26:0] exp_row(input int b, input int r);
    return {mdl[b][r][0], mdl[b][r][1], mdl[b][r][2]};
  endfunction

  // One write transaction; the model is updated only when the bench expects acceptance.
  task automatic do_write(input int b, input int r, input int c, input int s,
                          input logic exp_err, input bit verbose);
    wr_en    = 1'b1;
    wr_bank  = 1'(b);
    wr_row   = 4'(r);
    wr_col   = 2'(c);
    wr_shift = 9'(s);
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_err", {31'd0, wr_err}, {31'd0, exp_err});
    if (!exp_err) mdl[b][r][c] = 9'(s);
    if (verbose) $display("write bank=%0d row=%0d col=%0d shift=%0d wr_err=%0b", b, r, c, s, wr_err);
  endtask

  // Stream one bank; expected rows are queued at start and popped on each handshake.
  task automatic run_stream(input int b, input bit toggle);
    bit fin;
    bit ph;
    fin = 1'b0;
    ph  = 1'b0;
    sb.delete();
    for (int r = 0; r < 16; r++) sb.push_back('{idx: 4'(r), shifts: exp_row(b, r)});
    start = 1'b1;
    start_bank = 1'(b);
    @(negedge clk);
    start = 1'b0;
    chk("stream_busy", {31'd0, busy}, 32'd1);
    chk("stream_first_vld", {31'd0, row_vld}, 32'd1);
    chk("stream_start_err", {31'd0, start_err}, 32'd0);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (done) begin
        chk("done_all_rows", sb.size(), 32'd0);
        chk("done_vld_low", {31'd0, row_vld}, 32'd0);
        chk("done_shifts_zero", {5'd0, row_shifts}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        row_rdy = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        fin = 1'b1;
      end else begin
        chk("stream_vld", {31'd0, row_vld}, 32'd1);
        if (row_vld) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_row: got row %0d expected no further rows", row_idx);
          end else begin
            chk("row_idx", {28'd0, row_idx}, {28'd0, sb[0].idx});
            chk("row_shifts", {5'd0, row_shifts}, {5'd0, sb[0].shifts});
          end
        end
        row_rdy = toggle ? ph : 1'b1;
        ph = ~ph;
        if (row_vld && row_rdy && sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
      end
    end
    row_rdy = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got no done pulse expected done within 200 cycles");
    end
    $display("stream bank=%0d toggle=%0b rows_left=%0d", b, toggle, sb.size());
  endtask

  wvec_t vt[7];

  initial begin
    vt[0] = '{bank: 0, row: 0, col: 0, shift: 176, exp_err: 1'b0};
    vt[1] = '{bank: 0, row: 0, col: 1, shift: 1,   exp_err: 1'b0};
    vt[2] = '{bank: 0, row: 0, col: 2, shift: 499, exp_err: 1'b0};
    vt[3] = '{bank: 0, row: 0, col: 3, shift: 5,   exp_err: 1'b1};
    vt[4] = '{bank: 1, row: 5, col: 3, shift: 9,   exp_err: 1'b1};
    vt[5] = '{bank: 1, row: 0, col: 0, shift: 300, exp_err: 1'b0};
    vt[6] = '{bank: 1, row: 0, col: 0, shift: 301, exp_err: 1'b0};

    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 3; c++)
          mdl[b][r][c] = '0;

    rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_row = '0; wr_col = '0; wr_shift = '0;
    bank_clr = '0; start = 1'b0; start_bank = '0; abort = 1'b0; row_rdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vld", {31'd0, row_vld}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bank_ready", {30'd0, bank_ready}, 32'd0);
    chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_shifts", {5'd0, row_shifts}, 32'd0);

    // Table-driven writes, including out-of-range column rejects and a rewrite
    for (int i = 0; i < 7; i++)
      do_write(vt[i].bank, vt[i].row, vt[i].col, vt[i].shift, vt[i].exp_err, 1'b1);
    chk("partial_not_ready", {30'd0, bank_ready}, 32'd0);

    // Start on a partly loaded bank is refused
    start = 1'b1; start_bank = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("partial_start_err", {31'd0, start_err}, 32'd1);
    chk("partial_busy", {31'd0, busy}, 32'd0);
    chk("partial_vld", {31'd0, row_vld}, 32'd0);
    @(negedge clk);
    chk("start_err_pulse", {31'd0, start_err}, 32'd0);

    // Abort while idle has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Fill the remaining entries of both banks
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 3; c++)
          if (!(b == 0 && r == 0)) do_write(b, r, c, int'($urandom_range(0, 511)), 1'b0, 1'b0);
    chk("all_ready", {30'd0, bank_ready}, 32'd3);

    // Full stream of bank0 with row_rdy toggling every cycle
    run_stream(0, 1'b1);

    // Stalled stream of bank0: write lock, start-while-busy, then abort at row 5
    start = 1'b1; start_bank = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t1_vld", {31'd0, row_vld}, 32'd1);
    chk("t1_row_idx", {28'd0, row_idx}, 32'd0);
    chk("t1_row_shifts", {5'd0, row_shifts}, 32'h2C003F3);
    do_write(0, 1, 0, 7, 1'b1, 1'b1);
    do_write(1, 1, 0, 123, 1'b0, 1'b1);
    start = 1'b1; start_bank = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_err", {31'd0, start_err}, 32'd1);
    chk("stall_hold_idx", {28'd0, row_idx}, 32'd0);
    chk("stall_hold_shifts", {5'd0, row_shifts}, {5'd0, exp_row(0, 0)});
    chk("stall_busy", {31'd0, busy}, 32'd1);
    row_rdy = 1'b1;
    repeat (5) @(negedge clk);
    row_rdy = 1'b0;
    chk("abort_row_idx", {28'd0, row_idx}, 32'd5);
    chk("abort_row_shifts", {5'd0, row_shifts}, {5'd0, exp_row(0, 5)});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_vld", {31'd0, row_vld}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_shifts", {5'd0, row_shifts}, 32'd0);
    @(negedge clk);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    $display("abort at row 5 complete");

    // bank1 carries the write accepted during the lock; bank0 is unchanged
    run_stream(1, 1'b0);
    run_stream(0, 1'b0);

    // Clear and a same-bank write together: clear wins, data still written
    bank_clr = 2'b10;
    wr_en = 1'b1; wr_bank = 1'b1; wr_row = 4'd0; wr_col = 2'd0; wr_shift = 9'd5;
    @(negedge clk);
    bank_clr = 2'b00;
    wr_en = 1'b0;
    mdl[1][0][0] = 9'd5;
    chk("clr_ready", {30'd0, bank_ready}, 32'd1);
    chk("clr_wr_err", {31'd0, wr_err}, 32'd0);
    start = 1'b1; start_bank = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_start_err", {31'd0, start_err}, 32'd1);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    $display("bank1 clear complete");

    // Asynchronous reset in the middle of a stream
    start = 1'b1; start_bank = 1'b0;
    @(negedge clk);
    start = 1'b0;
    row_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_idx", {28'd0, row_idx}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", {31'd0, row_vld}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {30'd0, bank_ready}, 32'd0);
    chk("arst_idx", {28'd0, row_idx}, 32'd0);
    chk("arst_shifts", {5'd0, row_shifts}, 32'd0);
    row_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    $display("mid-stream reset complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
